// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
// Opcodes, FSM states, datapath mux selects and ALU/immediate codes.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR,
        S_UTYPE, S_MDU_START, S_MDU_WAIT, S_TRAP
    } state_t;

    typedef enum logic [2:0] {AM_ADD, AM_SUB, AM_PASSB, AM_R, AM_I} alu_mode_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef logic [3:0] alu_ctrl_t;
    localparam alu_ctrl_t ALU_ADD   = 4'b0000;
    localparam alu_ctrl_t ALU_SUB   = 4'b0001;
    localparam alu_ctrl_t ALU_AND   = 4'b0010;
    localparam alu_ctrl_t ALU_OR    = 4'b0011;
    localparam alu_ctrl_t ALU_XOR   = 4'b0100;
    localparam alu_ctrl_t ALU_SLT   = 4'b0101;
    localparam alu_ctrl_t ALU_SLTU  = 4'b0110;
    localparam alu_ctrl_t ALU_SLL   = 4'b0111;
    localparam alu_ctrl_t ALU_SRL   = 4'b1000;
    localparam alu_ctrl_t ALU_SRA   = 4'b1001;
    localparam alu_ctrl_t ALU_PASSB = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_MDU    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // funct3 010/011 are unused in the BRANCH major opcode
    function automatic logic branch_f3_legal(input logic [2:0] f3);
        return !(f3 == 3'b010 || f3 == 3'b011);
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic lt, input logic ltu);
        case (f3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// ALU operation decoder shared by register-register and register-immediate execution.
module rv_alu_dec
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] mode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_mode_t'(mode))
            AM_SUB:   alu_ctrl = ALU_SUB;
            AM_PASSB: alu_ctrl = ALU_PASSB;
            AM_R, AM_I: begin
                case (funct3)
                    // bit30 on an immediate op is imm data, except for SRAI
                    3'b000:  alu_ctrl = (alu_mode_t'(mode) == AM_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default:  alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences the shared ALU/memory datapath,
// handshakes with an external MDU and traps on illegal encodings.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter bit ENABLE_M   = 1'b1,
    parameter int ALU_CTRL_W = 4,
    parameter int IMM_SRC_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  funct7_0,
    input  logic                  Zero,
    input  logic                  Lt,
    input  logic                  Ltu,
    input  logic                  mdu_done,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [IMM_SRC_W-1:0]  ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  mdu_start,
    output logic                  instr_retired,
    output logic                  illegal
);

    state_t    state, state_nxt;
    alu_mode_t alu_mode;
    logic [2:0] imm_sel;
    alu_ctrl_t alu_ctrl;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OPC_LOAD, OPC_STORE: state_nxt = S_MEMADR;
                    OPC_OP:              state_nxt = !funct7_0 ? S_EXECR :
                                                     (ENABLE_M ? S_MDU_START : S_TRAP);
                    OPC_OP_IMM:          state_nxt = S_EXECI;
                    OPC_BRANCH:          state_nxt = S_BRANCH;
                    OPC_JAL:             state_nxt = S_JAL;
                    OPC_JALR:            state_nxt = S_JALR_ADR;
                    OPC_LUI, OPC_AUIPC:  state_nxt = S_UTYPE;
                    default:             state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR:    state_nxt = (op == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:   state_nxt = S_MEMWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB: state_nxt = S_FETCH;
            S_EXECR, S_EXECI, S_UTYPE:    state_nxt = S_ALUWB;
            S_BRANCH:    state_nxt = branch_f3_legal(funct3) ? S_FETCH : S_TRAP;
            S_JAL:       state_nxt = S_ALUWB;
            S_JALR_ADR:  state_nxt = S_JAL;
            S_MDU_START: state_nxt = S_MDU_WAIT;
            S_MDU_WAIT:  state_nxt = mdu_done ? S_FETCH : S_MDU_WAIT;
            S_TRAP:      state_nxt = S_TRAP;
            default:     state_nxt = S_FETCH;
        endcase
    end

    // Everything is forced quiet while reset is held, whatever the state.
    always_comb begin
        PCWrite = 1'b0; AdrSrc = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
        RegWrite = 1'b0; mdu_start = 1'b0; instr_retired = 1'b0; illegal = 1'b0;
        ResultSrc = RES_ALUOUT; ALUSrcA = SRCA_PC; ALUSrcB = SRCB_RS2;
        imm_sel = IMM_I; alu_mode = AM_ADD;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    IRWrite = 1'b1; PCWrite = 1'b1;
                    ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; imm_sel = IMM_B;
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM;
                    imm_sel = (op == OPC_STORE) ? IMM_S : IMM_I;
                end
                S_MEMREAD:  AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = RES_DATA; RegWrite = 1'b1; instr_retired = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc = 1'b1; MemWrite = 1'b1; instr_retired = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_RS2; alu_mode = AM_R;
                end
                S_EXECI: begin
                    ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; alu_mode = AM_I;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1; instr_retired = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_RS2; alu_mode = AM_SUB;
                    if (branch_f3_legal(funct3)) begin
                        PCWrite = branch_taken(funct3, Zero, Lt, Ltu);
                        instr_retired = 1'b1;
                    end
                end
                S_JAL: begin
                    ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; PCWrite = 1'b1;
                end
                S_JALR_ADR: begin
                    ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM;
                end
                S_UTYPE: begin
                    imm_sel = IMM_U; ALUSrcB = SRCB_IMM;
                    if (op == OPC_LUI) alu_mode = AM_PASSB;
                    else               ALUSrcA = SRCA_OLDPC;
                end
                S_MDU_START: mdu_start = 1'b1;
                S_MDU_WAIT: begin
                    if (mdu_done) begin
                        RegWrite = 1'b1; ResultSrc = RES_MDU; instr_retired = 1'b1;
                    end
                end
                S_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

    rv_alu_dec u_alu_dec (
        .mode     (alu_mode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_ctrl (alu_ctrl)
    );

    assign ALUControl = ALU_CTRL_W'(alu_ctrl);
    assign ImmSrc     = IMM_SRC_W'(imm_sel);

endmodule
